// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone B3 classic single-beat initiator with retry and optional timeout (WB_CMD_MASTER_TIMEOUT_EN)
module wb_cmd_master #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32,
    parameter int SEL_WIDTH = 4,
    parameter int MAX_RETRY = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [ADR_WIDTH-1:0] cmd_adr_i,
    input  logic [DAT_WIDTH-1:0] cmd_dat_i,
    input  logic [SEL_WIDTH-1:0] cmd_sel_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DAT_WIDTH-1:0] rsp_dat_o,
    output logic [1:0]           rsp_status_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [ADR_WIDTH-1:0] adr_o,
    output logic [DAT_WIDTH-1:0] dat_o,
    output logic [SEL_WIDTH-1:0] sel_o,
    input  logic [DAT_WIDTH-1:0] dat_i,
    input  logic                 ack_i,
    input  logic                 err_i,
    input  logic                 rty_i
);

    typedef enum logic [1:0] {IDLE, CYCLE, BACKOFF, RESP} state_t;

    localparam logic [3:0] MAX_RETRY_C = 4'(MAX_RETRY);

    state_t     state;
    state_t     state_next;
    logic       accept;
    logic       tmo_hit;
    logic [3:0] retry_cnt;

    // Ready is masked while reset is held so it reads 0 until release.
    assign cmd_ready_o = rst_i && (state == IDLE);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign cyc_o       = (state == CYCLE);
    assign stb_o       = (state == CYCLE);
    assign rsp_valid_o = (state == RESP);

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i || state != CYCLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    assign tmo_hit = (state == CYCLE) && (tmo_cnt == TMO_LAST);
`else
    // No counter: the strobe waits for a termination indefinitely.
    assign tmo_hit = 1'b0 & (TIMEOUT == 0);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CYCLE;
            CYCLE: begin
                if (err_i) begin
                    state_next = RESP;
                end else if (rty_i) begin
                    state_next = (retry_cnt < MAX_RETRY_C) ? BACKOFF : RESP;
                end else if (ack_i || tmo_hit) begin
                    state_next = RESP;
                end
            end
            BACKOFF: state_next = CYCLE;
            RESP:    if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            we_o         <= 1'b0;
            adr_o        <= '0;
            dat_o        <= '0;
            sel_o        <= '0;
            rsp_dat_o    <= '0;
            rsp_status_o <= 2'b00;
            retry_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_o         <= cmd_we_i;
                        adr_o        <= cmd_adr_i;
                        dat_o        <= cmd_dat_i;
                        sel_o        <= cmd_sel_i;
                        rsp_dat_o    <= '0;
                        rsp_status_o <= 2'b00;
                        retry_cnt    <= '0;
                    end
                end
                CYCLE: begin
                    if (err_i) begin
                        rsp_status_o <= 2'b01;
                    end else if (rty_i) begin
                        if (retry_cnt < MAX_RETRY_C) begin
                            retry_cnt <= retry_cnt + 4'd1;
                        end else begin
                            rsp_status_o <= 2'b10;
                        end
                    end else if (ack_i) begin
                        if (!we_o) rsp_dat_o <= dat_i;
                        rsp_status_o <= 2'b00;
                    end else if (tmo_hit) begin
                        rsp_status_o <= 2'b11;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - directed self-checking bench for wb_cmd_master
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_out;
    logic [3:0]  sel;
    logic [31:0] dat_in = '0;
    logic        ack = 1'b0, err = 1'b0, rty = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    wb_cmd_master #(
        .ADR_WIDTH(32), .DAT_WIDTH(32), .SEL_WIDTH(4), .MAX_RETRY(4), .TIMEOUT(8)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_dat_o(rsp_dat), .rsp_status_o(rsp_status),
        .cyc_o(cyc), .stb_o(stb), .we_o(we),
        .adr_o(adr), .dat_o(dat_out), .sel_o(sel),
        .dat_i(dat_in), .ack_i(ack), .err_i(err), .rty_i(rty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_we = w;
        cmd_adr = a;
        cmd_dat = d;
        cmd_sel = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    int  stb_cnt, bursts, idle_cnt, max_len, cur_len;
    logic prev_stb;

    initial begin
        // Reset state
        tick(); tick(); tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cyc", cyc, 0);
        check("rst_adr", adr, 0);
        check("rst_rsp", {rsp_status, rsp_dat}, 0);
        rst = 1'b1;
        tick();
        check("post_rst_ready", cmd_ready, 1);

        // Zero-wait write
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        check("wr_cyc_stb", {cyc, stb, we}, 3'b111);
        check("wr_bus", {adr, dat_out, 28'h0, sel}, {32'h10, 32'hDEADBEEF, 28'h0, 4'hF});
        check("wr_ready_low", cmd_ready, 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_cyc_drop", cyc, 0);
        check("wr_rsp", {rsp_status, rsp_dat}, 0);
        handshake();
        check("wr_done_ready", {rsp_valid, cmd_ready}, 2'b01);

        // Read, three wait states
        issue(1'b0, 32'h20, 32'h0, 4'hF);
        stb_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) break;
            if (stb) stb_cnt++;
            if (stb_cnt == 4) begin
                ack = 1'b1;
                dat_in = 32'h12345678;
            end
            tick();
            ack = 1'b0;
        end
        check("rd_stb_cycles", stb_cnt, 4);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp", {rsp_status, rsp_dat}, {2'b00, 32'h12345678});
        handshake();

        // Retry exhaustion
        rty = 1'b1;
        issue(1'b0, 32'h30, 32'h0, 4'h3);
        bursts = 0; idle_cnt = 0; max_len = 0; cur_len = 0; prev_stb = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid) break;
            if (stb) begin
                if (!prev_stb) bursts++;
                cur_len++;
                if (cur_len > max_len) max_len = cur_len;
            end else begin
                cur_len = 0;
                if (bursts > 0) idle_cnt++;
            end
            prev_stb = stb;
            tick();
        end
        check("rty_bursts", bursts, 5);
        check("rty_burst_len", max_len, 1);
        check("rty_idle_cycles", idle_cnt, 4);
        check("rty_rsp", {rsp_valid, rsp_status, rsp_dat}, {1'b1, 2'b10, 32'h0});
        tick();
        check("rty_ignored_in_resp", {rsp_valid, rsp_status}, 3'b110);
        rty = 1'b0;
        handshake();

        // err and ack together: err wins; then back-to-back read with rsp_ready held
        issue(1'b1, 32'h40, 32'h1111_2222, 4'h1);
        err = 1'b1; ack = 1'b1;
        tick();
        err = 1'b0; ack = 1'b0;
        check("err_rsp", {rsp_valid, rsp_status, rsp_dat}, {1'b1, 2'b01, 32'h0});
        handshake();
        check("err_then_ready", cmd_ready, 1);
        rsp_ready = 1'b1;
        issue(1'b0, 32'h44, 32'h0, 4'hF);
        ack = 1'b1; dat_in = 32'hCAFEF00D;
        tick();
        ack = 1'b0;
        check("b2b_rsp", {rsp_valid, rsp_status, rsp_dat}, {1'b1, 2'b00, 32'hCAFEF00D});
        tick();
        check("b2b_one_cycle", {rsp_valid, cmd_ready}, 2'b01);
        rsp_ready = 1'b0;

        // Silent slave
        issue(1'b0, 32'h50, 32'h0, 4'hF);
        stb_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) break;
            if (stb) stb_cnt++;
            tick();
        end
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        check("tmo_stb_cycles", stb_cnt, 8);
        check("tmo_rsp", {rsp_valid, cyc, rsp_status, rsp_dat}, {1'b1, 1'b0, 2'b11, 32'h0});
`else
        check("notmo_stb_cycles", stb_cnt, 20);
        check("notmo_still_busy", {rsp_valid, stb}, 2'b01);
        ack = 1'b1; dat_in = 32'h0000_55AA;
        tick();
        ack = 1'b0;
        check("notmo_late_ack", {rsp_valid, rsp_status, rsp_dat}, {1'b1, 2'b00, 32'h55AA});
`endif
        handshake();

        // Reset during a cycle, stray ack in IDLE
        issue(1'b1, 32'h60, 32'h7, 4'hF);
        check("rstmid_cyc_before", cyc, 1);
        rst = 1'b0;
        tick();
        check("rstmid_cyc_drop", {cyc, stb, rsp_valid, cmd_ready}, 4'b0000);
        tick();
        rst = 1'b1;
        tick();
        check("rstmid_after", {rsp_valid, cmd_ready, cyc}, 3'b010);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("stray_ack_ignored", {rsp_valid, cmd_ready, cyc}, 3'b010);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone B3 classic-cycle initiator that turns single-beat commands from a local valid/ready port into bus cycles on the master side of the system Wishbone bus. It handles ack, err and rty terminations, retries with a bounded count, and optionally aborts on timeout. Each command returns one response on a separate valid/ready port. It sits between on-chip control logic (audio pipeline control, wake-detect sequencer) and the bus intercon.

## Interface
- ADR_WIDTH, 32, address width
- DAT_WIDTH, 32, data width
- SEL_WIDTH, 4, byte-select width (DAT_WIDTH/8)
- MAX_RETRY, 4, re-issues allowed after rty_i before giving up (1..15)
- TIMEOUT, 255, cycles with stb_o high and no termination before abort (1..65535)

Ports. One clock; reset is synchronous and active-low.
- clk_i  in  1  bus clock
- rst_i  in  1  synchronous reset, active-low
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid&&ready
- cmd_we_i  in  1  1=write, 0=read
- cmd_adr_i  in  ADR_WIDTH  target address
- cmd_dat_i  in  DAT_WIDTH  write data
- cmd_sel_i  in  SEL_WIDTH  byte selects
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when valid&&ready
- rsp_dat_o  out  DAT_WIDTH  read data (0 for writes and failures)
- rsp_status_o  out  2  00 ok, 01 err, 10 retry exhausted, 11 timeout
- cyc_o, stb_o, we_o  out  1 each  Wishbone cycle, strobe, write enable
- adr_o  out  ADR_WIDTH; dat_o  out  DAT_WIDTH; sel_o  out  SEL_WIDTH
- dat_i  in  DAT_WIDTH  read data from slave
- ack_i, err_i, rty_i  in  1 each  terminations

## Operation
- States: IDLE, CYCLE, BACKOFF, RESP.
- IDLE: cmd_ready_o=1. On valid&&ready, register we/adr/dat/sel, clear the retry and timeout counters, and go to CYCLE.
- CYCLE: cyc_o=stb_o=1. we_o/adr_o/dat_o/sel_o come from the registered command and stay stable. Terminations are sampled on each edge. Priority is err_i > rty_i > ack_i.
  - ack: capture dat_i into rsp_dat_o if read, status 00, go to RESP.
  - err: status 01, go to RESP.
  - rty with retry count < MAX_RETRY: increment the count, go to BACKOFF.
  - rty otherwise: status 10, go to RESP.
- BACKOFF: cyc_o=stb_o=0 for exactly one cycle, then back to CYCLE with the same command. The timeout counter clears.
- RESP: rsp_valid_o=1 with status and data held stable until rsp_ready_i. On handshake, go to IDLE. cmd_ready_o=0 throughout.
- Terminations arriving outside CYCLE are ignored.
- lock_o is not driven; the intercon ties it to 0.

## Timing
- Reset values: cmd_ready_o=0, rsp_valid_o=0, rsp_dat_o=0, rsp_status_o=00, cyc_o=stb_o=we_o=0, adr_o=dat_o=sel_o=0. The state goes to IDLE, so cmd_ready_o=1 on the first cycle after rst_i rises.
- Accept at edge N. cyc_o/stb_o are high from cycle N+1.
- Zero-wait ack at edge N+1 gives rsp_valid_o high in cycle N+2. Minimum command-to-response latency is 2 cycles.
- cyc_o/stb_o drop on the same edge that samples the terminating ack/err.
- Each retry adds 1 BACKOFF cycle plus the re-issue.
- If rsp_ready_i is already high when rsp_valid_o rises, the response completes in 1 cycle and the next command is accepted no earlier than the following cycle.
- Reset low mid-cycle: cyc_o/stb_o go low at the next edge. The command is discarded and no response is produced.
- Timeout: the counter increments every CYCLE clock without a termination. When it reaches TIMEOUT, cyc_o/stb_o drop and status is 11. A termination on that same edge takes precedence over the timeout.

## Configuration
- WB_CMD_MASTER_TIMEOUT_EN defined: the timeout counter and status 11 are present as described.
- Not defined: no counter logic is built, CYCLE waits indefinitely for a termination, status 11 is never produced, and the TIMEOUT parameter is unused.

## Test plan
- Write adr=0x0000_0010, dat=0xDEADBEEF, sel=0xF, slave acks in the first stb cycle -> bus shows we_o=1 with the same values for 1 cycle; rsp status 00, rsp_dat_o=0, command-to-response latency 2 cycles.
- Read adr=0x20, slave acks after 3 wait cycles with dat_i=0x12345678 -> stb_o high 4 cycles; rsp_dat_o=0x12345678, status 00.
- Read with slave asserting rty_i on every attempt, MAX_RETRY=4 -> 5 stb bursts, each separated by exactly one idle cycle; status 10, rsp_dat_o=0.
- Slave asserts err_i and ack_i on the same edge -> status 01; a new command is accepted after rsp handshake.
- TIMEOUT=8 with WB_CMD_MASTER_TIMEOUT_EN defined and a silent slave -> stb_o high exactly 8 cycles, status 11. Without the macro -> stb_o stays high; a later ack yields status 00.
- rst_i driven low during CYCLE with rsp_ready_i held low -> cyc_o=0 next edge, no rsp_valid_o, cmd_ready_o=1 on the first cycle after release.
